mem_line_sequencer: RTL and testbench

MEM_LINE_SEQUENCER -- requirements
Module: mem_line_sequencer

---
 rtl/mem_line_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_mem_line_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_sequencer.sv
// Splits full-line read/write requests into per-subblock DRAM beats and
// reassembles read beats into a line, flagging out-of-order or stray beats.
module mem_line_sequencer #(
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned BLOCK_BITS = 256,
  parameter int unsigned SUBBLOCKS  = 4,
  parameter int unsigned SUB_LOG2   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_BITS-1:0]             req_addr,
  input  logic [BLOCK_BITS-1:0]            req_wdata,
  output logic                             resp_valid,
  output logic                             resp_we,
  output logic [BLOCK_BITS-1:0]            resp_rdata,
  output logic [ADDR_BITS-1:0]             mem_addr,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [SUB_LOG2-1:0]              mem_dinDstrobe,
  output logic [BLOCK_BITS/SUBBLOCKS-1:0]  mem_din,
  input  logic [SUB_LOG2-1:0]              mem_doutDstrobe,
  input  logic [BLOCK_BITS/SUBBLOCKS-1:0]  mem_dout,
  input  logic                             mem_dready,
  input  logic                             mem_accR,
  input  logic                             mem_accW,
  output logic                             proto_err
);

  localparam int unsigned BEAT_W   = BLOCK_BITS / SUBBLOCKS;
  localparam int unsigned OFF_BITS = $clog2(BLOCK_BITS / 8);
  localparam int unsigned CNT_W    = SUB_LOG2 + 1;
  localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'((1 << OFF_BITS) - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_BURST   = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_COLLECT = 3'd3,
    RESP       = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic [BLOCK_BITS-1:0]   wdata_q, wdata_d;
  logic [BLOCK_BITS-1:0]   line_q, line_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_we_q, resp_we_d;
  logic [BLOCK_BITS-1:0]   resp_rdata_q, resp_rdata_d;
  logic [ADDR_BITS-1:0]    mem_addr_q, mem_addr_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic [SUB_LOG2-1:0]     strobe_q, strobe_d;
  logic [BEAT_W-1:0]       din_q, din_d;
  logic                    proto_err_q, proto_err_d;

  logic                    wr_done;
  logic                    rd_last;
  logic                    collecting;

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_we        = resp_we_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_addr       = mem_addr_q;
  assign mem_en         = mem_en_q;
  assign mem_we         = mem_we_q;
  assign mem_dinDstrobe = strobe_q;
  assign mem_din        = din_q;
  assign proto_err      = proto_err_q;

  assign wr_done    = (beat_q == CNT_W'(SUBBLOCKS));
  assign rd_last    = (beat_q == CNT_W'(SUBBLOCKS - 1));
  assign collecting = (state_q == RD_ISSUE) || (state_q == RD_COLLECT);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    wdata_d      = wdata_q;
    line_d       = line_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_we_d    = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    strobe_d     = strobe_q;
    din_d        = din_q;
    proto_err_d  = proto_err_q;

    case (state_q)
      IDLE: begin
        if (mem_dready) proto_err_d = 1'b1;
        if (req_valid && req_ready_q) begin
          mem_addr_d = req_addr & ~OFF_MASK;
          wdata_d    = req_wdata;
          beat_d     = '0;
          if (req_we) begin
            state_d  = WR_BURST;
            mem_we_d = 1'b1;
            strobe_d = '0;
            din_d    = req_wdata[BEAT_W-1:0];
            beat_d   = CNT_W'(1);
          end else begin
            state_d  = RD_ISSUE;
            mem_en_d = 1'b1;
          end
        end else begin
          req_ready_d = mem_accR && mem_accW;
        end
      end
      WR_BURST: begin
        if (mem_dready) proto_err_d = 1'b1;
        if (wr_done) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_we_d    = 1'b1;
        end else begin
          mem_we_d = 1'b1;
          strobe_d = beat_q[SUB_LOG2-1:0];
          din_d    = wdata_q[32'(beat_q) * BEAT_W +: BEAT_W];
          beat_d   = beat_q + CNT_W'(1);
        end
      end
      RD_ISSUE:   state_d = RD_COLLECT;
      RD_COLLECT: state_d = RD_COLLECT;
      RESP: begin
        if (mem_dready) proto_err_d = 1'b1;
        state_d     = IDLE;
        req_ready_d = mem_accR && mem_accW;
      end
      default: state_d = IDLE;
    endcase

    // Beats land at their own strobe slot; completion is counted, not indexed
    if (collecting && mem_dready) begin
      line_d[32'(mem_doutDstrobe) * BEAT_W +: BEAT_W] = mem_dout;
      if ({1'b0, mem_doutDstrobe} != beat_q) proto_err_d = 1'b1;
      beat_d = beat_q + CNT_W'(1);
      if (rd_last) begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = line_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      wdata_q      <= '0;
      line_q       <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      strobe_q     <= '0;
      din_q        <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      wdata_q      <= wdata_d;
      line_q       <= line_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      strobe_q     <= strobe_d;
      din_q        <= din_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_mem_line_sequencer.sv
// Bench for mem_line_sequencer: timestamp-based transaction model checked every
// cycle, a small DRAM responder, and directed scenarios with literal expectations.
module tb_mem_line_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_we;
  logic [31:0]  req_addr;
  logic [255:0] req_wdata;
  logic         resp_valid, resp_we;
  logic [255:0] resp_rdata;
  logic [31:0]  mem_addr;
  logic         mem_en, mem_we;
  logic [1:0]   mem_dinDstrobe, mem_doutDstrobe;
  logic [63:0]  mem_din, mem_dout;
  logic         mem_dready, mem_accR, mem_accW;
  logic         proto_err;

  always #5 clk = ~clk;

  mem_line_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we),
    .mem_dinDstrobe(mem_dinDstrobe), .mem_din(mem_din),
    .mem_doutDstrobe(mem_doutDstrobe), .mem_dout(mem_dout),
    .mem_dready(mem_dready), .mem_accR(mem_accR), .mem_accW(mem_accW),
    .proto_err(proto_err)
  );

  localparam logic [255:0] WD  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] WD2 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] D3 = 64'hA5A5_5A5A_A5A5_5A5A;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- DRAM responder (read latency 5) ----------------
  logic [255:0] dram [0:31];
  logic         auto_mode;
  logic         a_rdy, i_rdy;
  logic [1:0]   a_strb, i_strb;
  logic [63:0]  a_dout, i_dout;
  logic         d_pend;
  int           d_wait, d_idx, d_line;

  assign mem_dready      = auto_mode ? a_rdy  : i_rdy;
  assign mem_doutDstrobe = auto_mode ? a_strb : i_strb;
  assign mem_dout        = auto_mode ? a_dout : i_dout;

  always @(negedge clk) begin
    if (!reset) begin
      d_pend = 1'b0;
      a_rdy  = 1'b0;
    end else begin
      a_rdy = 1'b0;
      if (mem_we) dram[mem_addr[9:5]][32'(mem_dinDstrobe) * 64 +: 64] = mem_din;
      if (d_pend) begin
        if (d_wait > 0) d_wait--;
        else begin
          a_rdy  = 1'b1;
          a_strb = 2'(d_idx);
          a_dout = dram[d_line][d_idx * 64 +: 64];
          d_idx++;
          if (d_idx == 4) d_pend = 1'b0;
        end
      end
      if (mem_en && auto_mode) begin
        d_pend = 1'b1;
        d_wait = 4;
        d_idx  = 0;
        d_line = int'(mem_addr[9:5]);
      end
    end
  end

  // ---------------- Transaction model (timestamps, cycle = edges since reset) --------
  int unsigned  cyc, m_a, m_resp, n_acc, n_resp;
  int           m_beats;
  logic         m_busy, m_we, m_done, m_accept;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata, m_line, e_rdata;
  logic         e_ready, e_rv, e_rwe, e_en, e_we, e_perr;
  logic [1:0]   e_strb;
  logic [63:0]  e_din;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc = 0; m_a = 0; m_resp = 0; m_beats = 0;
      m_busy = 1'b0; m_we = 1'b0; m_done = 1'b0;
      m_addr = '0; m_wdata = '0; m_line = '0; e_rdata = '0;
      e_ready = 1'b0; e_rv = 1'b0; e_rwe = 1'b0; e_en = 1'b0; e_we = 1'b0; e_perr = 1'b0;
      e_strb = '0; e_din = '0;
    end else begin
      cyc++;
      // a beat seen during cycle cyc-1 is legal only inside an open read window
      if (mem_dready) begin
        if (m_busy && !m_we && !m_done && (cyc - 1 >= m_a)) begin
          m_line[32'(mem_doutDstrobe) * 64 +: 64] = mem_dout;
          if (int'(mem_doutDstrobe) != m_beats) e_perr = 1'b1;
          m_beats++;
          if (m_beats == 4) begin
            m_done  = 1'b1;
            m_resp  = cyc;
            e_rdata = m_line;
          end
        end else begin
          e_perr = 1'b1;
        end
      end
      if (m_busy && cyc > m_resp) m_busy = 1'b0;
      m_accept = req_valid && e_ready;
      if (m_accept) begin
        m_busy  = 1'b1;
        m_we    = req_we;
        m_a     = cyc;
        m_addr  = {req_addr[31:5], 5'b0};
        m_wdata = req_wdata;
        m_beats = 0;
        m_done  = 1'b0;
        m_resp  = req_we ? cyc + 4 : 32'hFFFF_FFFF;
        n_acc++;
      end
      e_we = m_busy && m_we && (cyc >= m_a) && (cyc <= m_a + 3);
      if (e_we) begin
        e_strb = 2'(cyc - m_a);
        e_din  = m_wdata[(cyc - m_a) * 64 +: 64];
      end
      e_en  = m_busy && !m_we && (cyc == m_a);
      e_rv  = m_busy && (cyc == m_resp);
      e_rwe = e_rv && m_we;
      if (e_rv) n_resp++;
      e_ready = !m_busy && mem_accR && mem_accW;
    end
  end

  // ---------------- Per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset) begin
      chk("req_ready",  256'(req_ready),  256'(e_ready));
      chk("resp_valid", 256'(resp_valid), 256'(e_rv));
      chk("resp_we",    256'(resp_we),    256'(e_rwe));
      chk("resp_rdata", resp_rdata,       e_rdata);
      chk("mem_addr",   256'(mem_addr),   256'(m_addr));
      chk("mem_en",     256'(mem_en),     256'(e_en));
      chk("mem_we",     256'(mem_we),     256'(e_we));
      chk("proto_err",  256'(proto_err),  256'(e_perr));
      if (e_we) begin
        chk("mem_dinDstrobe", 256'(mem_dinDstrobe), 256'(e_strb));
        chk("mem_din",        256'(mem_din),        256'(e_din));
      end
    end else begin
      chk("rst_outputs", {req_ready, resp_valid, resp_we, mem_en, mem_we, proto_err,
                          mem_dinDstrobe, mem_din, mem_addr}, 256'(0));
      chk("rst_rdata", resp_rdata, 256'(0));
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic do_req(input logic we, input logic [31:0] a, input logic [255:0] d);
    int unsigned n0;
    n0 = n_acc;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_acc != n0) break;
    end
    req_valid = 1'b0;
    chk("accept_timeout", 256'(n_acc != n0), 256'(1));
  endtask

  task automatic wait_resp(output int en_seen);
    int unsigned n0;
    n0 = n_resp;
    en_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_en) en_seen++;
      if (n_resp != n0) break;
    end
    chk("resp_timeout", 256'(n_resp != n0), 256'(1));
  endtask

  logic [63:0] lit_w [4];
  logic [1:0]  inj_s [4];
  logic [63:0] inj_d [4];

  initial begin
    int en_cnt;
    int unsigned n0;
    lit_w = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
              64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    inj_s = '{2'd0, 2'd2, 2'd1, 2'd3};
    inj_d = '{D0, D1, D2, D3};
    for (int i = 0; i < 32; i++) dram[i] = '0;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_accR = 1'b1; mem_accW = 1'b1;
    auto_mode = 1'b1; i_rdy = 1'b0; i_strb = '0; i_dout = '0;
    a_rdy = 1'b0; a_strb = '0; a_dout = '0; d_pend = 1'b0;
    n_acc = 0; n_resp = 0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // line write: four beats in order, then completion
    do_req(1'b1, 32'h0000_1000, WD);
    for (int k = 0; k < 4; k++) begin
      chk("wr_we_lit",     256'(mem_we),         256'(1));
      chk("wr_strobe_lit", 256'(mem_dinDstrobe), 256'(k));
      chk("wr_din_lit",    256'(mem_din),        256'(lit_w[k]));
      chk("wr_en_lit",     256'(mem_en),         256'(0));
      @(negedge clk);
    end
    chk("wr_resp_lit", 256'({resp_valid, resp_we}), 256'(2'b11));
    @(negedge clk);

    // line read through the DRAM model, unaligned address
    do_req(1'b0, 32'h0000_1008, '0);
    chk("rd_addr_lit", 256'(mem_addr), 256'(32'h0000_1000));
    chk("rd_en_lit",   256'(mem_en),   256'(1));
    wait_resp(en_cnt);
    chk("rd_en_count", 256'(en_cnt), 256'(0));
    chk("rd_data_lit", resp_rdata, WD);
    chk("rd_we_lit",   256'(resp_we), 256'(0));
    @(negedge clk);

    // write, then read of same line held off by a draining write pipeline
    do_req(1'b1, 32'h0000_1040, WD2);
    mem_accW = 1'b0;
    n0 = n_acc;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_1040;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("accw_hold_ready", 256'(req_ready), 256'(0));
    end
    mem_accW = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n_acc != n0) break;
    end
    req_valid = 1'b0;
    chk("accw_accept", 256'(n_acc != n0), 256'(1));
    wait_resp(en_cnt);
    chk("wr_rd_data_lit", resp_rdata, WD2);
    @(negedge clk);

    // out-of-order beats: stored by strobe, error flagged, completion on 4th beat
    auto_mode = 1'b0;
    do_req(1'b0, 32'h0000_1080, '0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      i_rdy = 1'b1; i_strb = inj_s[i]; i_dout = inj_d[i];
      @(negedge clk);
    end
    i_rdy = 1'b0;
    chk("ooo_resp_lit", 256'(resp_valid), 256'(1));
    chk("ooo_perr_lit", 256'(proto_err),  256'(1));
    chk("ooo_line_lit", resp_rdata, {D3, D1, D2, D0});
    @(negedge clk);

    // reset in the middle of a read burst
    auto_mode = 1'b1;
    do_req(1'b0, 32'h0000_1000, '0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_beats == 2) break;
    end
    chk("beat2_reached", 256'(m_beats), 256'(2));
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_outs", {req_ready, resp_valid, resp_we, mem_en, mem_we, proto_err,
                         mem_addr}, 256'(0));
    chk("rst_mid_rdata", resp_rdata, 256'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    do_req(1'b0, 32'h0000_1040, '0);
    wait_resp(en_cnt);
    chk("post_rst_data_lit", resp_rdata, WD2);
    chk("post_rst_perr_lit", 256'(proto_err), 256'(0));
    @(negedge clk);

    // stray beat while idle
    auto_mode = 1'b0;
    i_rdy = 1'b1; i_strb = 2'd1; i_dout = D2;
    @(negedge clk);
    i_rdy = 1'b0;
    @(negedge clk);
    chk("idle_beat_perr_lit", 256'(proto_err),  256'(1));
    chk("idle_beat_rv_lit",   256'(resp_valid), 256'(0));
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
